tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have parameter W, default 1, giving the width in bits of each channel sample.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit, the slot strobe; a cycle with en=1 carries one TDM slot on din.
REQ-005 The block SHALL have port sync, input, 1 bit, the frame marker; it is sampled only when en=1 and marks slot 0.
REQ-006 The block SHALL have port din, input, W bits, the serial TDM sample stream.
REQ-007 The block SHALL have ports d0, d1, d2 and d3, outputs, W bits each, holding the registered channel outputs for slots 0..3.
REQ-008 The block SHALL have port frame_valid, output, 1 bit, a one-cycle pulse when d0..d3 update.
REQ-009 The block SHALL have port sel, output, 2 bits, the slot index expected at the next en=1 cycle.
REQ-010 The block SHALL have port err, output, 1 bit, a one-cycle framing-error pulse.

Function
REQ-011 The block SHALL implement a two-state FSM with states IDLE (unsynchronised) and RUN (synchronised).
REQ-012 The block SHALL hold a 2-bit slot counter cnt, and sel SHALL equal cnt.
REQ-013 The block SHALL hold shadow registers s0, s1 and s2, each W bits.
REQ-014 When en=0, the block SHALL hold all state, outputs SHALL hold, frame_valid=0 and err=0, and sync SHALL be ignored.
REQ-015 In IDLE with en=1 and sync=0, the block SHALL discard the sample and stay in IDLE.
REQ-016 In IDLE with en=1 and sync=1, the block SHALL set s0<=din, cnt<=1 and enter RUN.
REQ-017 In RUN with en=1, sync=0 and cnt in {1,2}, the block SHALL set s[cnt]<=din and cnt<=cnt+1.
REQ-018 In RUN with en=1, sync=0 and cnt=3, the block SHALL, at the same edge, set d0<=s0, d1<=s1, d2<=s2, d3<=din, frame_valid<=1 and cnt<=0.
REQ-019 Latency SHALL be one clock: d0..d3 and frame_valid become visible in the cycle after the slot-3 sample edge.
REQ-020 In RUN with en=1, cnt=0 and sync=1, the block SHALL treat the cycle as a normal frame start: s0<=din, cnt<=1, err=0.
REQ-021 In RUN with en=1, cnt=0 and sync=0 (missing sync), the block SHALL pulse err for one cycle, discard the sample, and go to IDLE with cnt<=0.
REQ-022 In RUN with en=1, cnt in {1,2,3} and sync=1 (early sync), the block SHALL pulse err for one cycle, discard the partial frame (d0..d3 unchanged, no frame_valid), and set s0<=din, cnt<=1, staying in RUN.
REQ-023 frame_valid and err SHALL never both be 1 in the same cycle.
REQ-024 d0..d3 SHALL change only on a frame_valid edge or on reset.
REQ-025 Back-to-back frames (en=1 continuously, sync every 4th slot) SHALL produce one frame_valid every 4 cycles with no dead cycle.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set state=IDLE, cnt=0, s0..s2=0, d0..d3=0, frame_valid=0 and err=0.
REQ-027 rst SHALL take priority over en, sync and din.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame, with no frame_valid or err afterward until a new sync.

Verification
REQ-029 The bench SHALL cover a basic frame: W=1, en=1, sync=1 with din=0, then din=1,0,1 -> the next cycle shows d0=0, d1=1, d2=0, d3=1 and frame_valid=1 for exactly one cycle; sel sequence 0,1,2,3,0.
REQ-030 The bench SHALL cover gapped strobes: the same frame with en=0 for 2 cycles between each slot -> identical d0..d3, one frame_valid, and outputs stable during gaps.
REQ-031 The bench SHALL cover back-to-back frames: frames 0101 then 1010 continuous -> frame_valid at cycles 5 and 9; d0..d3 go 0,1,0,1 then 1,0,1,0.
REQ-032 The bench SHALL cover early sync: sync at slot 2 -> err=1 for one cycle, d0..d3 keep their prior value, and the next full frame is captured correctly.
REQ-033 The bench SHALL cover missing sync and idle data: after a good frame, en=1 with sync=0 at slot 0 -> err pulse, sel=0, and IDLE ignores data until sync.
REQ-034 The bench SHALL cover reset mid-frame: rst=1 after 2 slots -> all outputs 0, and no frame_valid until a fresh sync plus 4 slots.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux -- four-slot TDM demultiplexer.
//
// A slot is one cycle with en=1; sync marks slot 0 of a frame. Slots 0..2
// are held in shadow registers. On the slot-3 strobe the complete frame is
// copied to d0..d3 and frame_valid pulses on the following cycle. Framing
// errors are reported with a one-cycle err pulse:
//   - sync arriving in the middle of a frame: the partial frame is dropped
//     and a new frame starts from that slot.
//   - sync missing at slot 0: the block drops back to the unsynchronised
//     state and waits for the next sync.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   en           slot strobe; din carries one slot when en=1
//   sync         frame marker, sampled only when en=1
//   din[W-1:0]   serial TDM sample stream
//   d0..d3       registered channel outputs for slots 0..3
//   frame_valid  one-cycle pulse when d0..d3 update
//   sel[1:0]     slot index expected at the next en=1 cycle
//   err          one-cycle framing-error pulse
module tdm_demux #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sync,
  input  logic [W-1:0] din,
  output logic [W-1:0] d0,
  output logic [W-1:0] d1,
  output logic [W-1:0] d2,
  output logic [W-1:0] d3,
  output logic         frame_valid,
  output logic [1:0]   sel,
  output logic         err
);

  typedef enum logic {
    IDLE = 1'b0,  // waiting for a sync
    RUN  = 1'b1   // locked to the frame
  } state_t;

  state_t       state, state_nx;
  logic [1:0]   cnt, cnt_nx;
  logic [W-1:0] s0, s1, s2;
  logic [W-1:0] s0_nx, s1_nx, s2_nx;
  logic [W-1:0] d0_nx, d1_nx, d2_nx, d3_nx;
  logic         frame_valid_nx, err_nx;

  assign sel = cnt;

  always_comb begin
    // NOTE: every signal gets a hold/idle default before any branch so that
    // no path leaves it unassigned; this is what keeps latches out.
    state_nx       = state;
    cnt_nx         = cnt;
    s0_nx          = s0;
    s1_nx          = s1;
    s2_nx          = s2;
    d0_nx          = d0;
    d1_nx          = d1;
    d2_nx          = d2;
    d3_nx          = d3;
    frame_valid_nx = 1'b0;
    err_nx         = 1'b0;

    if (en) begin
      unique case (state)
        IDLE: begin
          // Unsynchronised samples are dropped until a sync appears.
          if (sync) begin
            s0_nx    = din;
            cnt_nx   = 2'd1;
            state_nx = RUN;
          end
        end

        RUN: begin
          if (sync) begin
            // Sync at slot 0 is a normal frame start; anywhere else it aborts
            // the partial frame, which is restarted from this slot.
            err_nx = (cnt != 2'd0);
            s0_nx  = din;
            cnt_nx = 2'd1;
          end else begin
            unique case (cnt)
              2'd0: begin
                // Expected a frame start but sync is missing: lose lock.
                err_nx   = 1'b1;
                cnt_nx   = 2'd0;
                state_nx = IDLE;
              end
              2'd1: begin
                s1_nx  = din;
                cnt_nx = 2'd2;
              end
              2'd2: begin
                s2_nx  = din;
                cnt_nx = 2'd3;
              end
              2'd3: begin
                // Slot 3 goes straight to d3 so the frame publishes on this
                // edge with no extra cycle of latency.
                d0_nx          = s0;
                d1_nx          = s1;
                d2_nx          = s2;
                d3_nx          = din;
                frame_valid_nx = 1'b1;
                cnt_nx         = 2'd0;
              end
              default: ;
            endcase
          end
        end

        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values computed above.
    if (rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      // NOTE: the shadow registers are cleared on reset like the outputs so
      // that no stale sample from an aborted frame can ever be observed.
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      d0          <= '0;
      d1          <= '0;
      d2          <= '0;
      d3          <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      s0          <= s0_nx;
      s1          <= s1_nx;
      s2          <= s2_nx;
      d0          <= d0_nx;
      d1          <= d1_nx;
      d2          <= d2_nx;
      d3          <= d3_nx;
      frame_valid <= frame_valid_nx;
      err         <= err_nx;
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux -- self-checking bench for tdm_demux (W=1).
// A frame-level reference model (a queue of the samples collected for the
// current frame plus a locked flag) predicts every output after each edge.
module tb_tdm_demux;

  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] d0, d1, d2, d3;
  logic         frame_valid, err;
  logic [1:0]   sel;

  int n_checks = 0;
  int n_pass   = 0;

  tdm_demux #(.W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .din(din),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .frame_valid(frame_valid), .sel(sel), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0]   fbuf[$];   // samples of the frame being collected
  bit             locked;
  logic [4*W-1:0] exp_d;     // {d3,d2,d1,d0}
  logic           exp_fv, exp_err;
  logic [1:0]     exp_sel;

  function automatic void model_edge(input logic r, e, s, input logic [W-1:0] x);
    exp_fv  = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      locked = 1'b0;
      fbuf.delete();
      exp_d  = '0;
    end else if (e) begin
      if (!locked) begin
        if (s) begin fbuf = '{x}; locked = 1'b1; end
      end else if (s) begin
        if (fbuf.size() != 0) exp_err = 1'b1;
        fbuf = '{x};
      end else if (fbuf.size() == 0) begin
        exp_err = 1'b1;
        locked  = 1'b0;
      end else begin
        fbuf.push_back(x);
        if (fbuf.size() == 4) begin
          exp_d  = {fbuf[3], fbuf[2], fbuf[1], fbuf[0]};
          exp_fv = 1'b1;
          fbuf.delete();
        end
      end
    end
    exp_sel = 2'(fbuf.size());
  endfunction

  // Drive one cycle (inputs change on the falling edge), advance the model
  // at the rising edge, and return 1 time unit later so outputs are settled.
  task automatic cycle(input logic r, e, s, input logic [W-1:0] x);
    @(negedge clk);
    rst = r; en = e; sync = s; din = x;
    @(posedge clk);
    model_edge(r, e, s, x);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++; if ({d3, d2, d1, d0} !== 4'b0000) $display("FAIL reset d: got %b want 0000", {d3, d2, d1, d0}); else n_pass++;
    n_checks++; if (sel !== 2'd0) $display("FAIL reset sel: got %0d want 0", sel); else n_pass++;
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL reset fv: got %b want 0", frame_valid); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_basic();
    logic [3:0] dat = 4'b1010;         // din sequence 0,1,0,1
    logic [1:0] want_sel[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, i < 4, i == 0, dat[i % 4]);
      n_checks++; if (sel !== want_sel[i]) $display("FAIL basic sel[%0d]: got %0d want %0d", i, sel, want_sel[i]); else n_pass++;
      n_checks++; if (frame_valid !== (i == 3)) $display("FAIL basic fv[%0d]: got %b want %b", i, frame_valid, i == 3); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL basic err[%0d]: got %b want 0", i, err); else n_pass++;
    end
    n_checks++; if ({d3, d2, d1, d0} !== 4'b1010) $display("FAIL basic d: got %b want 1010", {d3, d2, d1, d0}); else n_pass++;
  endtask

  task automatic test_gapped();
    logic [3:0] dat = 4'b1010;
    logic [3:0] held;
    int fv_seen = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, i == 0, dat[i]);
      if (frame_valid === 1'b1) fv_seen++;
      held = {d3, d2, d1, d0};
      for (int g = 0; g < 2; g++) begin
        cycle(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        n_checks++; if ({d3, d2, d1, d0} !== held || frame_valid !== 1'b0 || err !== 1'b0)
          $display("FAIL gap stable[%0d.%0d]: got d=%b fv=%b err=%b want d=%b fv=0 err=0", i, g, {d3, d2, d1, d0}, frame_valid, err, held);
        else n_pass++;
        n_checks++; if (sel !== exp_sel) $display("FAIL gap sel[%0d.%0d]: got %0d want %0d", i, g, sel, exp_sel); else n_pass++;
      end
    end
    n_checks++; if (fv_seen != 1) $display("FAIL gap fv count: got %0d want 1", fv_seen); else n_pass++;
    n_checks++; if ({d3, d2, d1, d0} !== 4'b1010) $display("FAIL gap d: got %b want 1010", {d3, d2, d1, d0}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] dat = 8'b0101_1010;    // 0,1,0,1 then 1,0,1,0
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, (i % 4) == 0, dat[i]);
      n_checks++; if (frame_valid !== (i == 3 || i == 7)) $display("FAIL b2b fv[%0d]: got %b want %b", i, frame_valid, (i == 3 || i == 7)); else n_pass++;
      if (i == 3) begin
        n_checks++; if ({d3, d2, d1, d0} !== 4'b1010) $display("FAIL b2b d frame0: got %b want 1010", {d3, d2, d1, d0}); else n_pass++;
      end
      if (i == 7) begin
        n_checks++; if ({d3, d2, d1, d0} !== 4'b0101) $display("FAIL b2b d frame1: got %b want 0101", {d3, d2, d1, d0}); else n_pass++;
      end
    end
  endtask

  task automatic test_early_sync();
    logic [3:0] good = 4'b0011;        // din 1,1,0,0
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, i == 0, good[i]);
    n_checks++; if ({d3, d2, d1, d0} !== 4'b0011) $display("FAIL early first d: got %b want 0011", {d3, d2, d1, d0}); else n_pass++;
    cycle(1'b0, 1'b1, 1'b1, 1'b0);     // slot 0
    cycle(1'b0, 1'b1, 1'b0, 1'b1);     // slot 1
    cycle(1'b0, 1'b1, 1'b1, 1'b1);     // sync at slot 2
    n_checks++; if (err !== 1'b1 || frame_valid !== 1'b0) $display("FAIL early err: got err=%b fv=%b want err=1 fv=0", err, frame_valid); else n_pass++;
    n_checks++; if ({d3, d2, d1, d0} !== 4'b0011) $display("FAIL early d held: got %b want 0011", {d3, d2, d1, d0}); else n_pass++;
    n_checks++; if (sel !== 2'd1) $display("FAIL early sel: got %0d want 1", sel); else n_pass++;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (err !== 1'b0) $display("FAIL early err width: got %b want 0", err); else n_pass++;
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (frame_valid !== 1'b1 || {d3, d2, d1, d0} !== 4'b0101)
      $display("FAIL early recovery: got fv=%b d=%b want fv=1 d=0101", frame_valid, {d3, d2, d1, d0});
    else n_pass++;
  endtask

  task automatic test_missing_sync();
    logic [3:0] good = 4'b1001;        // din 1,0,0,1
    logic [3:0] next = 4'b0110;        // din 0,1,1,0
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, i == 0, good[i]);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);     // slot 0 without sync
    n_checks++; if (err !== 1'b1 || sel !== 2'd0 || {d3, d2, d1, d0} !== 4'b1001)
      $display("FAIL missing err: got err=%b sel=%0d d=%b want err=1 sel=0 d=1001", err, sel, {d3, d2, d1, d0});
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(1)));
      n_checks++; if (err !== 1'b0 || frame_valid !== 1'b0 || sel !== 2'd0)
        $display("FAIL idle ignore[%0d]: got err=%b fv=%b sel=%0d want 0,0,0", i, err, frame_valid, sel);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, i == 0, next[i]);
    n_checks++; if (frame_valid !== 1'b1 || {d3, d2, d1, d0} !== 4'b0110)
      $display("FAIL missing resync: got fv=%b d=%b want fv=1 d=0110", frame_valid, {d3, d2, d1, d0});
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);     // reset wins over en
    n_checks++; if ({d3, d2, d1, d0} !== 4'b0000 || sel !== 2'd0 || frame_valid !== 1'b0 || err !== 1'b0)
      $display("FAIL midrst outputs: got d=%b sel=%0d fv=%b err=%b want all 0", {d3, d2, d1, d0}, sel, frame_valid, err);
    else n_pass++;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, i == 0, 1'b1);
      n_checks++; if (frame_valid !== (i == 3) || err !== 1'b0)
        $display("FAIL midrst fv[%0d]: got fv=%b err=%b want fv=%b err=0", i, frame_valid, err, i == 3);
      else n_pass++;
    end
    n_checks++; if ({d3, d2, d1, d0} !== 4'b1111) $display("FAIL midrst d: got %b want 1111", {d3, d2, d1, d0}); else n_pass++;
  endtask

  task automatic test_random();
    logic r, e, s, x;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(99) < 2);
      e = ($urandom_range(99) < 75);
      s = ($urandom_range(99) < 35);
      x = 1'($urandom_range(1));
      cycle(r, e, s, x);
      n_checks++; if ({d3, d2, d1, d0} !== exp_d) $display("FAIL rand d[%0d]: got %b want %b", i, {d3, d2, d1, d0}, exp_d); else n_pass++;
      n_checks++; if (frame_valid !== exp_fv) $display("FAIL rand fv[%0d]: got %b want %b", i, frame_valid, exp_fv); else n_pass++;
      n_checks++; if (err !== exp_err) $display("FAIL rand err[%0d]: got %b want %b", i, err, exp_err); else n_pass++;
      n_checks++; if (sel !== exp_sel) $display("FAIL rand sel[%0d]: got %0d want %0d", i, sel, exp_sel); else n_pass++;
      n_checks++; if (frame_valid === 1'b1 && err === 1'b1) $display("FAIL rand fv_and_err[%0d]: got 1,1 want not both", i); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
